dcache_ctrl: RTL and testbench

- Direct-mapped, write-back L1 data cache controller between the core's 32-bit load/store port and the 128-bit line memory bus of the Avalon master.
- Serves hits with zero added latency.
- Handles misses by writing back the dirty victim line as one 4-beat burst, then filling the line with one 4-beat burst.
- Stalls the core until the line is installed.

---
 rtl/dcache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back L1 data cache controller: 32-bit core port, 128-bit line bursts.
// Optional DCACHE_STATS_EN adds hit_count/miss_count performance counters.
`timescale 1ns/1ps
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 4
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [31:0]  cpu_addr,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_be,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_stall,
    output logic [31:0]  mem_address,
    output logic         mem_read,
    output logic         mem_write,
    output logic [127:0] mem_write_value,
    output logic [2:0]   mem_burstcount,
    input  logic         mem_wait,
    input  logic         mem_write_ready_n,
    input  logic [127:0] mem_read_value
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {StIdle, StWbReq, StWbWait, StFillReq, StFillWait} state_e;

    state_e                     r_state;
    logic [LINES-1:0]           r_valid;
    logic [LINES-1:0]           r_dirty;
    logic [TAG_BITS-1:0]        r_tag  [LINES];
    logic [3:0][31:0]           r_data [LINES];
    logic [INDEX_BITS-1:0]      r_miss_index;
    logic [TAG_BITS-1:0]        r_miss_tag;
    logic                       r_wb_seen;
    logic                       r_fill_seen;
    logic                       r_mem_read;
    logic                       r_mem_write;
    logic [31:0]                r_mem_address;
    logic [127:0]               r_mem_wvalue;
`ifdef DCACHE_STATS_EN
    logic [31:0]                r_hit_count;
    logic [31:0]                r_miss_count;
`endif

    logic [INDEX_BITS-1:0]      w_index;
    logic [TAG_BITS-1:0]        w_tag;
    logic [1:0]                 w_word;
    logic                       w_req;
    logic                       w_match;
    logic                       w_hit;
    logic                       w_miss;
    logic                       w_fill_done;
    logic [31:0]                w_merged_word;
    logic                       w_unused;

    assign w_index  = cpu_addr[INDEX_BITS+3:4];
    assign w_tag    = cpu_addr[31 -: TAG_BITS];
    assign w_word   = cpu_addr[3:2];
    assign w_unused = ^cpu_addr[1:0];

    assign w_req       = cpu_read | cpu_write;
    assign w_match     = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_hit       = w_req && w_match && (r_state == StIdle);
    assign w_miss      = w_req && !w_match && (r_state == StIdle);
    assign w_fill_done = (r_state == StFillWait) && r_fill_seen && !mem_wait;

    assign cpu_stall = w_req && !w_hit;
    assign cpu_rdata = w_hit ? r_data[w_index][w_word] : 32'd0;

    always_comb begin
        w_merged_word = r_data[w_index][w_word];
        for (int b = 0; b < 4; b++) begin
            if (cpu_be[b]) begin
                w_merged_word[b*8 +: 8] = cpu_wdata[b*8 +: 8];
            end
        end
    end

    // Data/tag arrays and the latched miss address deliberately carry no reset.
    always_ff @(posedge clk) begin
        if (w_hit && cpu_write) begin
            r_data[w_index][w_word] <= w_merged_word;
        end else if (w_fill_done) begin
            r_data[r_miss_index] <= mem_read_value;
            r_tag[r_miss_index]  <= r_miss_tag;
        end
        if (w_miss) begin
            r_miss_index <= w_index;
            r_miss_tag   <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state       <= StIdle;
            r_valid       <= '0;
            r_dirty       <= '0;
            r_wb_seen     <= 1'b0;
            r_fill_seen   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_wvalue  <= 128'd0;
`ifdef DCACHE_STATS_EN
            r_hit_count   <= 32'd0;
            r_miss_count  <= 32'd0;
`endif
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
`ifdef DCACHE_STATS_EN
            if (w_hit) r_hit_count <= r_hit_count + 32'd1;
            if (w_miss) r_miss_count <= r_miss_count + 32'd1;
`endif
            case (r_state)
                StIdle: begin
                    if (w_hit && cpu_write) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                    if (w_miss) begin
                        if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state       <= StWbReq;
                            r_mem_write   <= 1'b1;
                            r_mem_address <= {r_tag[w_index], w_index, 4'b0000};
                            r_mem_wvalue  <= r_data[w_index];
                        end else begin
                            r_state       <= StFillReq;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= {w_tag, w_index, 4'b0000};
                        end
                    end
                end
                StWbReq: r_state <= StWbWait;
                StWbWait: begin
                    if (mem_write_ready_n) begin
                        r_wb_seen <= 1'b1;
                    end else if (r_wb_seen) begin
                        r_wb_seen     <= 1'b0;
                        r_state       <= StFillReq;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= {r_miss_tag, r_miss_index, 4'b0000};
                    end
                end
                StFillReq: r_state <= StFillWait;
                StFillWait: begin
                    if (mem_wait) begin
                        r_fill_seen <= 1'b1;
                    end else if (r_fill_seen) begin
                        r_fill_seen           <= 1'b0;
                        r_valid[r_miss_index] <= 1'b1;
                        r_dirty[r_miss_index] <= 1'b0;
                        r_mem_address         <= 32'd0;
                        r_state               <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_mem_address;
    assign mem_write_value = r_mem_wvalue;
    assign mem_burstcount  = 3'd4;
`ifdef DCACHE_STATS_EN
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold fill, hits, store merge, dirty eviction, mid-fill reset.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         clrn;
    logic [31:0]  cpu_addr;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_be;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_write_value;
    logic [2:0]   mem_burstcount;
    logic         mem_wait;
    logic         mem_write_ready_n;
    logic [127:0] mem_read_value;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] WA  = 32'hA0A1_A2A3;
    localparam logic [31:0] WB  = 32'hB0B1_B2B3;
    localparam logic [31:0] WC  = 32'hC0C1_C2C3;
    localparam logic [31:0] WD  = 32'hD0D1_D2D3;
    localparam logic [31:0] WAM = 32'hA0AA_A2A3;
    localparam logic [127:0] LINE1  = {WD, WC, WB, WA};
    localparam logic [127:0] LINE1M = {WD, WC, WB, WAM};
    localparam logic [127:0] LINE2  = {32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk              (clk),
        .clrn             (clrn),
        .cpu_addr         (cpu_addr),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_wdata        (cpu_wdata),
        .cpu_be           (cpu_be),
        .cpu_rdata        (cpu_rdata),
        .cpu_stall        (cpu_stall),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_write_value  (mem_write_value),
        .mem_burstcount   (mem_burstcount),
        .mem_wait         (mem_wait),
        .mem_write_ready_n(mem_write_ready_n),
        .mem_read_value   (mem_read_value)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2 ns after a rising edge and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clrn = 1'b0; cpu_addr = 32'd0; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_wdata = 32'd0; cpu_be = 4'd0; mem_wait = 1'b0; mem_write_ready_n = 1'b0;
        mem_read_value = 128'd0;
        step(); step();
        clrn = 1'b1;
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("burstcount", mem_burstcount, 4);

        // Cold load of 0x104
        step();
        cpu_read = 1'b1; cpu_addr = 32'h0000_0104;
        #1;
        chk("cold_stall", cpu_stall, 1);
        step();
        mem_wait = 1'b1;
        #1;
        chk("fill_rd_pulse", mem_read, 1);
        chk("fill_addr", mem_address, 32'h0000_0100);
        chk("fill_no_wr", mem_write, 0);
        chk("fill_stall", cpu_stall, 1);
        step();
        #1;
        chk("fill_rd_once", mem_read, 0);
        step();
        mem_wait = 1'b0; mem_read_value = LINE1;
        #1;
        chk("fill_stall_late", cpu_stall, 1);
        step();
        #1;
        chk("cold_done_stall", cpu_stall, 0);
        chk("cold_rdata_B", cpu_rdata, WB);
        chk("idle_addr_zero", mem_address, 0);

        // Hit on 0x10C
        step();
        cpu_addr = 32'h0000_010C;
        #1;
        chk("hit_stall", cpu_stall, 0);
        chk("hit_rdata_D", cpu_rdata, WD);
        chk("hit_no_rd", mem_read, 0);
        chk("hit_no_wr", mem_write, 0);

        // Store hit, byte 2
        step();
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'h0000_0100;
        cpu_wdata = 32'h00AA_0000; cpu_be = 4'b0100;
        #1;
        chk("st_stall", cpu_stall, 0);
        step();
        cpu_write = 1'b0; cpu_read = 1'b1; cpu_be = 4'd0;
        #1;
        chk("st_merged", cpu_rdata, WAM);
        chk("st_ld_stall", cpu_stall, 0);

        // Conflict miss on 0x500 with dirty victim
        step();
        cpu_addr = 32'h0000_0500;
        #1;
        chk("evict_stall", cpu_stall, 1);
        step();
        mem_write_ready_n = 1'b1;
        #1;
        chk("wb_pulse", mem_write, 1);
        chk("wb_no_rd", mem_read, 0);
        chk("wb_addr", mem_address, 32'h0000_0100);
        chk("wb_value", mem_write_value, LINE1M);
        step();
        #1;
        chk("wb_once", mem_write, 0);
        chk("wb_hold1", mem_write_value, LINE1M);
        step();
        mem_write_ready_n = 1'b0;
        #1;
        chk("wb_hold2", mem_write_value, LINE1M);
        chk("wb_wait_stall", cpu_stall, 1);
        chk("wb_wait_no_rd", mem_read, 0);
        step();
        mem_wait = 1'b1; mem_read_value = LINE2;
        #1;
        chk("refill_rd", mem_read, 1);
        chk("refill_addr", mem_address, 32'h0000_0500);
        chk("refill_no_wr", mem_write, 0);
        step(); step();
        mem_wait = 1'b0;
        #1;
        chk("refill_stall", cpu_stall, 1);
        step();
        #1;
        chk("refill_hit_stall", cpu_stall, 0);
        chk("refill_rdata", cpu_rdata, 32'h5000_0000);
`ifdef DCACHE_STATS_EN
        chk("miss_count", miss_count, 2);
        chk("hit_count_pre", hit_count, 4);
`endif

        // Reset during FILL_WAIT of a reload of 0x100
        step();
        cpu_addr = 32'h0000_0100;
        #1;
`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, 5);
`endif
        chk("reload_stall", cpu_stall, 1);
        step();
        mem_wait = 1'b1;
        #1;
        chk("reload_rd", mem_read, 1);
        chk("reload_addr", mem_address, 32'h0000_0100);
        step();
        clrn = 1'b0;
        #1;
        chk("fw_no_rd", mem_read, 0);
        step();
        clrn = 1'b1; mem_wait = 1'b0;
        #1;
        chk("mid_rst_rd", mem_read, 0);
        chk("mid_rst_wr", mem_write, 0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_wval", mem_write_value, 0);
        chk("mid_rst_stall", cpu_stall, 1);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_count", hit_count, 0);
`endif
        step();
        mem_wait = 1'b1; mem_read_value = LINE1M;
        #1;
        chk("remiss_rd", mem_read, 1);
        chk("remiss_addr", mem_address, 32'h0000_0100);
        chk("remiss_no_wr", mem_write, 0);
        step(); step();
        mem_wait = 1'b0;
        #1;
        step();
        #1;
        chk("remiss_done", cpu_stall, 0);
        chk("remiss_rdata", cpu_rdata, WAM);

        step();
        cpu_read = 1'b0;
        #1;
        chk("noreq_rdata", cpu_rdata, 0);
        chk("noreq_stall", cpu_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
